dmg_timer_multi: RTL

//  Parametrised successor of the DMG divider/timer. A free-running divider feeds N_CH

---
 rtl/dmg_timer_multi_pkg.sv | 26 ++
 rtl/dmg_timer_multi_chan.sv | 123 ++++++++++++
 rtl/dmg_timer_multi.sv | 91 +++++++++
 3 files changed

// File: rtl/dmg_timer_multi_pkg.sv
// Shared definitions for the multi-channel DMG-style timer: register offsets,
// CTL bit positions, channel FSM encoding and the tap lookup.
package dmg_timer_multi_pkg;

  localparam int ADDR_DIV    = 0;
  localparam int REG_STRIDE  = 3;
  localparam int REG_CNT     = 0;
  localparam int REG_MOD     = 1;
  localparam int REG_CTL     = 2;

  localparam int CTL_SEL_LSB = 0;
  localparam int CTL_EN      = 2;
  localparam int CTL_ONESHOT = 3;

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RELOAD = 2'd2
  } chan_state_e;

  // TAPS packs one 4-bit divider index per sel value, sel=0 in the low nibble.
  function automatic logic [3:0] tap_idx(input logic [15:0] taps, input logic [1:0] sel);
    return taps[sel*4 +: 4];
  endfunction

endpackage

// File: rtl/dmg_timer_multi_chan.sv
// One reloadable timer channel: CNT/MOD/CTL registers, tap falling-edge detector,
// overflow/reload sequencer and its wait counter.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_COUNT  | CNT advances on each tap falling edge
//  ST_WAIT   | post-overflow delay, CNT reads 0, ticks ignored, CNT write aborts
//  ST_RELOAD | one clk: CNT already holds MOD, irq high, MOD write reloads CNT too
module dmg_timer_multi_chan
  import dmg_timer_multi_pkg::*;
#(
  parameter int          DIV_W   = 16,
  parameter int          CNT_W   = 8,
  parameter logic [15:0] TAPS    = {4'd7, 4'd5, 4'd3, 4'd9},
  parameter int          RLD_DLY = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cnt_we_i,
  input  logic             mod_we_i,
  input  logic             ctl_we_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       cnt_o,
  output logic [7:0]       mod_o,
  output logic [7:0]       ctl_o,
  output logic             irq_o
);

  localparam int WC_W = $clog2(RLD_DLY + 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mod_q, mod_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             os_q, os_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             t_q;
  logic             t;
  logic             tick;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_COUNT;
      cnt_q   <= '0;
      mod_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      os_q    <= 1'b0;
      wcnt_q  <= '0;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      os_q    <= os_d;
      wcnt_q  <= wcnt_d;
      t_q     <= t;
    end
  end

  always_comb begin
    t       = en_q & div_i[tap_idx(TAPS, sel_q)];
    tick    = t_q & ~t;
    state_d = state_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    sel_d   = sel_q;
    en_d    = en_q;
    os_d    = os_q;
    wcnt_d  = wcnt_q;

    if (mod_we_i) mod_d = din_i[CNT_W-1:0];
    if (ctl_we_i) begin
      sel_d = din_i[CTL_SEL_LSB +: 2];
      en_d  = din_i[CTL_EN];
      os_d  = din_i[CTL_ONESHOT];
    end

    case (state_q)
      ST_COUNT: begin
        if (cnt_we_i) begin
          cnt_d = din_i[CNT_W-1:0];
        end else if (tick) begin
          if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d   = '0;
            wcnt_d  = WC_W'(RLD_DLY);
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_we_i) begin
          cnt_d   = din_i[CNT_W-1:0];
          state_d = ST_COUNT;
        end else if (wcnt_q == WC_W'(1)) begin
          cnt_d   = mod_d;
          state_d = ST_RELOAD;
          if (os_q) en_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q - WC_W'(1);
        end
      end
      ST_RELOAD: begin
        // CNT writes are dropped here; a MOD write lands in CNT as well.
        if (mod_we_i) cnt_d = din_i[CNT_W-1:0];
        state_d = ST_COUNT;
      end
      default: state_d = ST_COUNT;
    endcase
  end

  assign cnt_o = 8'(cnt_q);
  assign mod_o = 8'(mod_q);
  assign ctl_o = {4'b0000, os_q, en_q, sel_q};
  assign irq_o = (state_q == ST_RELOAD);

endmodule

// File: rtl/dmg_timer_multi.sv
// Multi-channel DMG timer top: free-running divider, register decode, read mux
// with registered dout, and N_CH independent timer channels.
module dmg_timer_multi
  import dmg_timer_multi_pkg::*;
#(
  parameter int          DIV_W   = 16,
  parameter int          CNT_W   = 8,
  parameter int          N_CH    = 1,
  parameter logic [15:0] TAPS    = {4'd7, 4'd5, 4'd3, 4'd9},
  parameter int          RLD_DLY = 4,
  parameter int          ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              rd,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [N_CH-1:0]   irq
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       dout_q, dout_d;
  logic [N_CH-1:0]  cnt_we, mod_we, ctl_we;
  logic [7:0]       cnt_rd [N_CH];
  logic [7:0]       mod_rd [N_CH];
  logic [7:0]       ctl_rd [N_CH];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_q  <= '0;
      dout_q <= '0;
    end else begin
      div_q  <= div_d;
      dout_q <= dout_d;
    end
  end

  // Unmapped addresses fall through to 8'hFF and match no write enable.
  always_comb begin
    cnt_we = '0;
    mod_we = '0;
    ctl_we = '0;
    dout_d = 8'hFF;
    div_d  = div_q + DIV_W'(1);
    if (addr == ADDR_W'(ADDR_DIV)) begin
      dout_d = div_q[DIV_W-1 -: 8];
      if (wr) div_d = '0;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (addr == ADDR_W'(1 + REG_STRIDE*c + REG_CNT)) begin
        cnt_we[c] = wr;
        dout_d    = cnt_rd[c];
      end
      if (addr == ADDR_W'(1 + REG_STRIDE*c + REG_MOD)) begin
        mod_we[c] = wr;
        dout_d    = mod_rd[c];
      end
      if (addr == ADDR_W'(1 + REG_STRIDE*c + REG_CTL)) begin
        ctl_we[c] = wr;
        dout_d    = ctl_rd[c];
      end
    end
    if (!rd) dout_d = dout_q;
  end

  assign dout = dout_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    dmg_timer_multi_chan #(
      .DIV_W  (DIV_W),
      .CNT_W  (CNT_W),
      .TAPS   (TAPS),
      .RLD_DLY(RLD_DLY)
    ) u_chan (
      .clk     (clk),
      .nreset  (nreset),
      .div_i   (div_q),
      .cnt_we_i(cnt_we[g]),
      .mod_we_i(mod_we[g]),
      .ctl_we_i(ctl_we[g]),
      .din_i   (din),
      .cnt_o   (cnt_rd[g]),
      .mod_o   (mod_rd[g]),
      .ctl_o   (ctl_rd[g]),
      .irq_o   (irq[g])
    );
  end

endmodule
